// File: rtl/alu_pkg.sv
// Shared ALU opcode, flag-index and queue-entry definitions.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT1 = 3'b110;
  localparam logic [2:0] OP_NOT2 = 3'b111;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_DZ = 2;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] result;
    logic [2:0]  flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_sanitize.sv
// Combinational result clean-up and {dz, n, z} flag derivation.
module alu_result_sanitize
  import alu_pkg::*;
(
  input  logic [2:0]  opcode,
  input  logic [15:0] inp2,
  input  logic [31:0] result,
  output logic [31:0] san_result,
  output logic [2:0]  flags
);

  // Only the low 15 bits of the divisor select divide-by-zero.
  logic unused_inp2_msb;
  assign unused_inp2_msb = inp2[15];

  logic div_zero;
  assign div_zero = (opcode == OP_DIV) &&
                    (inp2[14:0] == 15'd0);

  always_comb begin
    san_result = result;
    flags      = '0;
    unique case (1'b1)
      opcode[2]: san_result[31:16] = '0;
      div_zero: begin
        san_result     = '0;
        flags[FLAG_DZ] = 1'b1;
      end
      default: ;
    endcase
    if (opcode[2]) begin
      flags[FLAG_Z] = (san_result[15:0] == 16'd0);
      flags[FLAG_N] = san_result[15];
    end else begin
      flags[FLAG_Z] = (san_result == 32'd0);
      flags[FLAG_N] = san_result[31];
    end
  end

endmodule

// File: rtl/alu_result_queue.sv
// Registered FIFO stage behind the 16-bit ALU with valid/ready handshake.
// Optional empty-queue bypass: define ALU_RESULT_QUEUE_BYPASS_EN.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_opcode,
  input  logic [15:0]                in_inp2,
  input  logic [31:0]                in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_opcode,
  output logic [31:0]                out_result,
  output logic [2:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_entry_t       mem [DEPTH];
  alu_entry_t       in_entry;
  alu_entry_t       head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      san_result;
  logic [2:0]       san_flags;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;

  alu_result_sanitize u_sanitize (
    .opcode     (in_opcode),
    .inp2       (in_inp2),
    .result     (in_result),
    .san_result (san_result),
    .flags      (san_flags)
  );

  assign in_entry = '{
    opcode: in_opcode,
    result: san_result,
    flags:  san_flags
  };

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;

`ifdef ALU_RESULT_QUEUE_BYPASS_EN
  assign bypass    = empty && in_valid && out_ready;
  assign out_valid = !empty || bypass;
  assign head      = bypass ? in_entry : mem[rd_ptr];
`else
  assign bypass    = 1'b0;
  assign out_valid = !empty;
  assign head      = mem[rd_ptr];
`endif

  // A bypassed entry is consumed directly and never touches storage.
  assign push = in_valid && in_ready && !bypass;
  assign pop  = out_valid && out_ready && !bypass;

  assign out_opcode = head.opcode;
  assign out_result = head.result;
  assign out_flags  = head.flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_entry;
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue with directed vectors.
module tb_alu_result_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [15:0] in_inp2;
  logic [31:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [$clog2(DEPTH):0] count;

  alu_entry_t pend;
  alu_entry_t sb [$];
  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU_RESULT_QUEUE_BYPASS_EN
  localparam int STEADY = 0;
`else
  localparam int STEADY = 1;
`endif

  alu_result_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_inp2    (in_inp2),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_result (out_result),
    .out_flags  (out_flags),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0]  op,
                       input logic [15:0] i2,
                       input logic [31:0] res,
                       input logic [31:0] eres,
                       input logic [2:0]  efl);
    in_valid  = 1'b1;
    in_opcode = op;
    in_inp2   = i2;
    in_result = res;
    pend      = '{opcode: op, result: eres, flags: efl};
  endtask

  // Records accepted entries, then checks whatever the DUT hands out.
  always @(negedge clk) begin
    alu_entry_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(pend);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_opcode", 32'(out_opcode), 32'(e.opcode));
          check("out_result", out_result, e.result);
          check("out_flags", 32'(out_flags), 32'(e.flags));
          check("out_result_known",
                32'($isunknown(out_result)), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_inp2   = '0;
    in_result = '0;
    out_ready = 1'b0;
    pend      = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Zero ADD result, one-cycle latency
    drive(OP_ADD, 16'd3, 32'h0, 32'h0, 3'b001);
    cyc();
    in_valid = 1'b0;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_count", 32'(count), 32'd1);
    check("lat_flags", 32'(out_flags), 32'd1);
    out_ready = 1'b1;
    cyc();
    check("pop_count", 32'(count), 32'd0);
    check("pop_out_valid", 32'(out_valid), 32'd0);

    // Sanitization vectors, back-to-back with out_ready high
    drive(OP_OR, 16'd0, 32'hXXXX_00F0, 32'h0000_00F0, 3'b000);
    cyc();
    drive(OP_DIV, 16'h8000, 32'h1234_5678, 32'h0, 3'b101);
    cyc();
    drive(OP_MUL, 16'd2, 32'h8000_0000, 32'h8000_0000, 3'b010);
    cyc();
    drive(OP_AND, 16'd0, 32'hFFFF_8000, 32'h0000_8000, 3'b010);
    cyc();
    drive(OP_NOT1, 16'd0, 32'h1234_0000, 32'h0, 3'b001);
    cyc();
    drive(OP_SUB, 16'd1, 32'h0000_0005, 32'h0000_0005, 3'b000);
    cyc();
    drive(OP_DIV, 16'd5, 32'h0000_0007, 32'h0000_0007, 3'b000);
    cyc();
    in_valid = 1'b0;
    check("vec_count", 32'(count), 32'(STEADY));
    cyc();
    check("vec_drained", 32'(count), 32'd0);

    // Fill to full, refuse fifth, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(OP_SUB, 16'd1, 32'hA0 + 32'(i), 32'hA0 + 32'(i), 3'b000);
      cyc();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    drive(OP_SUB, 16'd1, 32'hA4, 32'hA4, 3'b000);
    cyc();
    check("refused_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    cyc();
    check("full_pop_no_push", 32'(count), 32'd3);
    cyc();
    check("push_pop_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && count != 0; i++) cyc();
    check("drain_count", 32'(count), 32'd0);

    // Sustained streaming through pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(OP_ADD, 16'd1, 32'h100 + 32'(i), 32'h100 + 32'(i), 3'b000);
      cyc();
      check("stream_count", 32'(count), 32'(STEADY));
    end
    in_valid = 1'b0;
    cyc();
    check("stream_drained", 32'(count), 32'd0);

    // Reset with stored entries and a pending push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(OP_ADD, 16'd1, 32'd1 + 32'(i), 32'd1 + 32'(i), 3'b000);
      cyc();
    end
    check("pre_rst_count", 32'(count), 32'd3);
    drive(OP_ADD, 16'd1, 32'h55, 32'h55, 3'b000);
    rst = 1'b1;
    cyc();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // Queue still works after the mid-run reset
    out_ready = 1'b1;
    drive(OP_NOT2, 16'd0, 32'hABCD_0000, 32'h0, 3'b001);
    cyc();
    in_valid = 1'b0;
    cyc();
    check("post_rst_count", 32'(count), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Registered output stage that sits directly downstream of the combinational 16-bit ALU operator. Each cycle it can accept one ALU result together with the opcode and second operand that produced it. It sanitizes the 32-bit result and derives status flags. It then buffers the entry in a small FIFO and presents it to the consumer through a valid/ready handshake. Buffering decouples the consumer from the ALU and guarantees no X ever leaves the ALU path.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers an entry
- in_ready  output  1  queue can accept; equals !full
- in_opcode  input  3  opcode applied to the ALU for this result
- in_inp2  input  16  second ALU operand, used only for divide-by-zero detection
- in_result  input  32  raw ALU result
- out_valid  output  1  head entry available
- out_ready  input  1  consumer takes head entry
- out_opcode  output  3  opcode of head entry
- out_result  output  32  sanitized result of head entry
- out_flags  output  3  {dz, n, z} of head entry
- count  output  $clog2(DEPTH)+1  number of stored entries

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Sanitization happens before storage:
  - Opcodes 100–111 (OR/AND/NOT): result[31:16] forced to 0.
  - Opcode 011 with in_inp2[14:0] == 0: result forced to 32'h0 and dz = 1.
  - In every other case dz = 0 and the result is stored unchanged.
- Flags are computed on the sanitized value:
  - Opcodes 000–011: z = (result == 0), n = result[31].
  - Opcodes 1xx: z = (result[15:0] == 0), n = result[15].
- Any X/Z bit in the stored result fields after sanitization is a producer error. The bench flags it; the RTL does not mask it.
- Storage is a circular buffer with write and read pointers of log2(DEPTH) bits. Pointers wrap naturally at DEPTH.
- count increments on push-only, decrements on pop-only, and holds on push+pop or on neither.
- Full means count == DEPTH. Empty means count == 0.
- in_ready = !full, derived from registered count only. A push is refused when full, even if a pop happens in the same cycle.
- Push+pop in the same cycle while non-empty and not full: both take effect and count is unchanged.
- out_valid = !empty, except in bypass mode (see Configuration).
- out_* fields are driven from the head entry. Their values are don't-care while out_valid = 0.
- Once out_valid is asserted, out_opcode, out_result and out_flags stay stable until the pop.

## Timing
- Reset values: count = 0, out_valid = 0, in_ready = 1, pointers = 0. Memory contents are not cleared.
- Base latency: an entry pushed at edge k is visible on out_* after edge k, i.e. one cycle from in_valid to out_valid.
- Throughput: one entry per cycle sustained when out_ready is held at 1.
- Reset asserted mid-operation: all stored entries are discarded at that edge. out_valid = 0 from the next cycle. A push or pop coinciding with reset is ignored.
- No combinational path from in_valid or out_ready to in_ready.

## Configuration
- ALU_RESULT_QUEUE_BYPASS_EN defined: when the queue is empty, in_valid = 1 and out_ready = 1, the sanitized input is driven combinationally onto out_* with out_valid = 1.
  - The entry is consumed in that cycle and nothing is written; count stays 0.
  - This adds an in_valid → out_valid combinational path. in_ready is unaffected.
- Undefined: no bypass; minimum latency is 1 cycle.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants: OP_ADD = 3'b000, OP_SUB, OP_MUL, OP_DIV, OP_OR, OP_AND, OP_NOT1, OP_NOT2.
  - Flag bit indices: FLAG_Z = 0, FLAG_N = 1, FLAG_DZ = 2.
  - The packed entry typedef {opcode, result, flags}.
- Sub-module alu_result_sanitize is purely combinational: opcode, inp2 and result in; sanitized result and flags out. It is shared by the write path and the bypass path.

## Test plan
- Reset, then push ADD with result 32'h0000_0000 → after 1 cycle out_valid = 1, out_flags = 3'b001, count = 1; pop → count = 0.
- Push OR with in_result = 32'hXXXX_00F0 → out_result = 32'h0000_00F0, out_flags = 3'b000.
- Push DIV with in_inp2 = 16'h8000 → out_result = 0, out_flags = 3'b101 (dz = 1, z = 1).
- With out_ready = 0, push 5 entries at DEPTH = 4 → fourth push makes in_ready = 0, fifth is refused, count = 4. Then assert out_ready with in_valid held → entries drain in order, and the fifth is accepted only after count drops below 4.
- Continuous push/pop for 10 cycles with out_ready = 1 → pointers wrap, order preserved, count steady at 1 without bypass or 0 with bypass.
- Assert rst with count = 3 and a push pending → next cycle count = 0, out_valid = 0, in_ready = 1, and the pending push is lost.
